// File: rtl/soc_bus_fabric_if.sv
// CPU-side and peripheral-side signals of the SoC bus fabric in one bundle.
// The fabric uses the slave modport; the CPU and peripherals (or a bench) sit on the master side.
interface soc_bus_fabric_if #(
  parameter int NUM_SLAVES = 4,
  parameter int DATA_W     = 32
);
  // Handshake: mem_rstrb / nonzero mem_wmask are one-cycle request pulses, honoured only
  // while mem_rbusy and mem_wbusy are both low. The fabric answers with a one-cycle one-hot
  // s_ren/s_wen pulse; the selected slave later pulses s_rvalid/s_wready for one cycle.
  // Responses from slaves that were not selected are ignored.
  logic [31:0]                  mem_addr;
  logic [DATA_W-1:0]            mem_wdata;
  logic [DATA_W/8-1:0]          mem_wmask;
  logic                         mem_rstrb;
  logic [DATA_W-1:0]            mem_rdata;
  logic                         mem_rbusy;
  logic                         mem_wbusy;

  logic [31:0]                  s_addr;
  logic [DATA_W-1:0]            s_wdata;
  logic [DATA_W/8-1:0]          s_wstrb;
  logic [NUM_SLAVES-1:0]        s_ren;
  logic [NUM_SLAVES-1:0]        s_wen;
  logic [NUM_SLAVES*DATA_W-1:0] s_rdata;
  logic [NUM_SLAVES-1:0]        s_rvalid;
  logic [NUM_SLAVES-1:0]        s_wready;

  modport master (
    output mem_addr, mem_wdata, mem_wmask, mem_rstrb,
    input  mem_rdata, mem_rbusy, mem_wbusy,
    input  s_addr, s_wdata, s_wstrb, s_ren, s_wen,
    output s_rdata, s_rvalid, s_wready
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_wmask, mem_rstrb,
    output mem_rdata, mem_rbusy, mem_wbusy,
    output s_addr, s_wdata, s_wstrb, s_ren, s_wen,
    input  s_rdata, s_rvalid, s_wready
  );
endinterface

// File: rtl/soc_bus_fabric.sv
// Region-decoded CPU-to-peripheral fabric: one outstanding access, per-access timeout,
// error response for unmapped or silent slaves, and a sticky first-error log.
module soc_bus_fabric #(
  parameter int                NUM_SLAVES = 4,
  parameter int                DATA_W     = 32,
  parameter int                SEL_MSB    = 31,
  parameter int                SEL_LSB    = 28,
  parameter int                TIMEOUT    = 15,
  parameter logic [DATA_W-1:0] ERR_DATA   = DATA_W'(32'hDEADBEEF)
) (
  input  logic               clk,
  input  logic               reset_n,
  soc_bus_fabric_if.slave    bus,
  input  logic               err_clr,
  output logic               bus_err,
  output logic [31:0]        err_addr,
  output logic [1:0]         dbg_state
);

  localparam int SEL_W = SEL_MSB - SEL_LSB + 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [31:0] SEL_MASK = 32'(((64'd1 << SEL_W) - 64'd1) << SEL_LSB);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2,
    ERR_RSP = 2'd3
  } state_t;

  state_t                state, state_nxt;
  logic [SEL_W-1:0]      idx, idx_q;
  logic [31:0]           addr_q;
  logic                  wr_q;
  logic [CNT_W-1:0]      cnt;
  logic [DATA_W-1:0]     rdata_q;
  logic [NUM_SLAVES-1:0] hit;
  logic [NUM_SLAVES-1:0] ren, wen;
  logic                  mapped, wr_req, rd_req, timed_out;
  logic [DATA_W-1:0]     sel_rdata;
  logic                  sel_rvalid, sel_wready;

  assign idx       = bus.mem_addr[SEL_MSB:SEL_LSB];
  assign wr_req    = |bus.mem_wmask;
  // A write beats a simultaneous read; the read is simply dropped.
  assign rd_req    = bus.mem_rstrb & ~wr_req;
  assign mapped    = |hit;
  assign timed_out = (cnt == CNT_W'(TIMEOUT - 1));

  // Decode of the live request address.
  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      hit[i] = (idx == SEL_W'(i));
    end
  end

  // Response mux driven by the latched index so other slaves cannot complete the access.
  always_comb begin
    sel_rdata  = '0;
    sel_rvalid = 1'b0;
    sel_wready = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (idx_q == SEL_W'(i)) begin
        sel_rdata  = bus.s_rdata[i*DATA_W +: DATA_W];
        sel_rvalid = bus.s_rvalid[i];
        sel_wready = bus.s_wready[i];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    ren       = '0;
    wen       = '0;
    case (state)
      IDLE: begin
        if (wr_req) begin
          if (mapped) begin
            wen       = hit;
            state_nxt = WR_WAIT;
          end else begin
            state_nxt = ERR_RSP;
          end
        end else if (rd_req) begin
          if (mapped) begin
            ren       = hit;
            state_nxt = RD_WAIT;
          end else begin
            state_nxt = ERR_RSP;
          end
        end
      end
      RD_WAIT: begin
        if (sel_rvalid)     state_nxt = IDLE;
        else if (timed_out) state_nxt = ERR_RSP;
      end
      WR_WAIT: begin
        if (sel_wready)     state_nxt = IDLE;
        else if (timed_out) state_nxt = ERR_RSP;
      end
      ERR_RSP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q    <= '0;
      addr_q   <= '0;
      wr_q     <= 1'b0;
      cnt      <= '0;
      rdata_q  <= '0;
      bus_err  <= 1'b0;
      err_addr <= '0;
    end else begin
      if (state == IDLE && (wr_req || rd_req)) begin
        idx_q  <= idx;
        addr_q <= bus.mem_addr;
        wr_q   <= wr_req;
      end

      // Zero outside the wait states, so every wait starts counting from 0.
      if (state == RD_WAIT || state == WR_WAIT) cnt <= cnt + CNT_W'(1);
      else                                      cnt <= '0;

      if (state == RD_WAIT && sel_rvalid)  rdata_q <= sel_rdata;
      else if (state == ERR_RSP && !wr_q)  rdata_q <= ERR_DATA;

      // A new error is logged even when err_clr arrives in the same cycle.
      if (state == ERR_RSP && (!bus_err || err_clr)) begin
        bus_err  <= 1'b1;
        err_addr <= addr_q;
      end else if (err_clr) begin
        bus_err  <= 1'b0;
        err_addr <= '0;
      end
    end
  end

  assign bus.mem_rdata = rdata_q;
  assign bus.mem_rbusy = (state == RD_WAIT) | ((state == ERR_RSP) & ~wr_q);
  assign bus.mem_wbusy = (state == WR_WAIT) | ((state == ERR_RSP) &  wr_q);
  assign bus.s_addr    = bus.mem_addr & ~SEL_MASK;
  assign bus.s_wdata   = bus.mem_wdata;
  assign bus.s_wstrb   = bus.mem_wmask;
  assign bus.s_ren     = ren;
  assign bus.s_wen     = wen;
  assign dbg_state     = state;

endmodule

// File: tb/tb_soc_bus_fabric.sv
// Directed bench for soc_bus_fabric: an access-level model plus per-cycle comparison,
// and hand-computed expectations for each scenario.
module tb_soc_bus_fabric;

  localparam int          NS       = 4;
  localparam int          DW       = 32;
  localparam int          TO       = 15;
  localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset_n;
  logic        err_clr;
  logic        bus_err;
  logic [31:0] err_addr;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  soc_bus_fabric_if #(.NUM_SLAVES(NS), .DATA_W(DW)) bus ();

  soc_bus_fabric #(
    .NUM_SLAVES(NS), .DATA_W(DW), .SEL_MSB(31), .SEL_LSB(28),
    .TIMEOUT(TO), .ERR_DATA(ERR_DATA)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .err_clr  (err_clr),
    .bus_err  (bus_err),
    .err_addr (err_addr),
    .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // ---------------- access-level model ----------------
  // An access is "busy" from the cycle after its request. A mapped access completes in the
  // first busy cycle (1..TO) where its own slave answers; past TO, or immediately when the
  // region is unmapped, one more busy cycle is spent producing the error response.
  logic              m_busy = 1'b0;
  logic              m_wr = 1'b0;
  logic [31:0]       m_addr = '0;
  int                m_sel = 0;
  int                m_age = 0;
  logic [31:0]       m_rdata = '0;
  logic              m_err = 1'b0;
  logic [31:0]       m_err_addr = '0;
  logic [DW-1:0]     exp_q[$];
  int                in_sel;
  logic              m_err_now, m_resp_now;
  logic [NS-1:0]     e_ren, e_wen;

  always_comb in_sel = int'(bus.mem_addr[31:28]);

  always_comb begin
    m_err_now  = m_busy && (m_sel >= NS || m_age > TO);
    m_resp_now = 1'b0;
    if (m_busy && m_sel < NS) m_resp_now = m_wr ? bus.s_wready[m_sel] : bus.s_rvalid[m_sel];
  end

  always_comb begin
    e_ren = '0;
    e_wen = '0;
    if (!m_busy && in_sel < NS) begin
      if (bus.mem_wmask != 0)  e_wen[in_sel] = 1'b1;
      else if (bus.mem_rstrb)  e_ren[in_sel] = 1'b1;
    end
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy     <= 1'b0;
      m_rdata    <= '0;
      m_err      <= 1'b0;
      m_err_addr <= '0;
      exp_q.delete();
    end else begin
      if (!m_busy) begin
        if (bus.mem_wmask != 0 || bus.mem_rstrb) begin
          m_busy <= 1'b1;
          m_wr   <= (bus.mem_wmask != 0);
          m_addr <= bus.mem_addr;
          m_sel  <= in_sel;
          m_age  <= 1;
        end
      end else if (m_err_now) begin
        m_busy <= 1'b0;
        if (!m_wr) begin
          m_rdata <= ERR_DATA;
          exp_q.push_back(ERR_DATA);
        end
      end else if (m_resp_now) begin
        m_busy <= 1'b0;
        if (!m_wr) begin
          m_rdata <= bus.s_rdata[m_sel*DW +: DW];
          exp_q.push_back(bus.s_rdata[m_sel*DW +: DW]);
        end
      end else begin
        m_age <= m_age + 1;
      end

      if (m_err_now && (!m_err || err_clr)) begin
        m_err      <= 1'b1;
        m_err_addr <= m_addr;
      end else if (err_clr) begin
        m_err      <= 1'b0;
        m_err_addr <= '0;
      end
    end
  end

  // ---------------- compare process (negedge) ----------------
  bit   cmp_on = 1'b0;
  logic prev_rbusy = 1'b0;

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("s_ren", bus.s_ren, e_ren);
      chk("s_wen", bus.s_wen, e_wen);
      chk("rbusy", bus.mem_rbusy, m_busy && !m_wr);
      chk("wbusy", bus.mem_wbusy, m_busy && m_wr);
      chk("mem_rdata", bus.mem_rdata, m_rdata);
      chk("bus_err", bus_err, m_err);
      chk("err_addr", err_addr, m_err_addr);
      if (e_ren != 0 || e_wen != 0) begin
        chk("s_addr", bus.s_addr, {4'h0, bus.mem_addr[27:0]});
        chk("s_wdata", bus.s_wdata, bus.mem_wdata);
        chk("s_wstrb", bus.s_wstrb, bus.mem_wmask);
      end
      if (!reset_n) begin
        prev_rbusy <= 1'b0;
      end else begin
        if (prev_rbusy && !bus.mem_rbusy) begin
          chk("rd_q_nonempty", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) chk("rd_result", bus.mem_rdata, exp_q.pop_front());
        end
        prev_rbusy <= bus.mem_rbusy;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one request, optionally answers it from the selected slave in busy cycle resp_at
  // (0 = never), and counts busy cycles over a fixed window that always covers a timeout.
  task automatic do_access(input logic [31:0] addr, input logic [3:0] wmask,
                           input logic [31:0] wdata, input bit rd_too, input int resp_at,
                           input logic [31:0] rdata, input bit noise,
                           output int rb, output int wb,
                           output logic [7:0] stb, output logic [31:0] saddr);
    int sel;
    bit is_wr;
    sel   = int'(addr[31:28]);
    is_wr = (wmask != 0);
    bus.mem_addr  = addr;
    bus.mem_wdata = wdata;
    bus.mem_wmask = wmask;
    bus.mem_rstrb = !is_wr || rd_too;
    @(negedge clk);
    stb   = {bus.s_wen, bus.s_ren};
    saddr = bus.s_addr;
    step();
    bus.mem_wmask = '0;
    bus.mem_rstrb = 1'b0;
    rb = 0;
    wb = 0;
    for (int k = 1; k <= TO + 4; k++) begin
      if (noise && k == 1) begin
        bus.mem_rstrb                = 1'b1;
        bus.s_rvalid[(sel + 1) % NS] = 1'b1;
        bus.s_wready[(sel + 1) % NS] = 1'b1;
      end
      if (k == resp_at && sel < NS) begin
        if (is_wr) begin
          bus.s_wready[sel] = 1'b1;
        end else begin
          bus.s_rvalid[sel]           = 1'b1;
          bus.s_rdata[sel*DW +: DW]   = rdata;
        end
      end
      @(negedge clk);
      if (bus.mem_rbusy) rb++;
      if (bus.mem_wbusy) wb++;
      step();
      bus.mem_rstrb = 1'b0;
      bus.s_rvalid  = '0;
      bus.s_wready  = '0;
    end
  endtask

  // ---------------- directed scenarios ----------------
  int          rb, wb;
  logic [7:0]  stb;
  logic [31:0] saddr;

  initial begin
    reset_n       = 1'b0;
    err_clr       = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_wmask = '0;
    bus.mem_rstrb = 1'b0;
    bus.s_rdata   = '0;
    bus.s_rvalid  = '0;
    bus.s_wready  = '0;
    repeat (2) step();
    @(negedge clk);
    chk("rst_rbusy", bus.mem_rbusy, 0);
    chk("rst_wbusy", bus.mem_wbusy, 0);
    chk("rst_rdata", bus.mem_rdata, 0);
    chk("rst_bus_err", bus_err, 0);
    chk("rst_err_addr", err_addr, 0);
    chk("rst_state", dbg_state, 0);
    step();
    reset_n = 1'b1;
    cmp_on  = 1'b1;
    step();

    // 1: zero-wait read from slave 0
    do_access(32'h0000_0010, 4'h0, 32'h0, 1'b0, 1, 32'h1234_5678, 1'b0, rb, wb, stb, saddr);
    chk("t1_strobe", stb, 8'h01);
    chk("t1_rbusy_cycles", rb, 1);
    chk("t1_rdata", bus.mem_rdata, 32'h1234_5678);

    // 2: write to slave 1, ready in the third busy cycle, stray requests/responses ignored
    do_access(32'h1000_0004, 4'hF, 32'hCAFE_F00D, 1'b0, 3, 32'h0, 1'b1, rb, wb, stb, saddr);
    chk("t2_strobe", stb, 8'h20);
    chk("t2_wbusy_cycles", wb, 3);
    chk("t2_s_addr", saddr, 32'h0000_0004);
    chk("t2_rdata_held", bus.mem_rdata, 32'h1234_5678);

    // 3: unmapped region
    do_access(32'h5000_0000, 4'h0, 32'h0, 1'b0, 0, 32'h0, 1'b0, rb, wb, stb, saddr);
    chk("t3_strobe", stb, 8'h00);
    chk("t3_rbusy_cycles", rb, 1);
    chk("t3_rdata", bus.mem_rdata, 32'hDEAD_BEEF);
    chk("t3_bus_err", bus_err, 1);
    chk("t3_err_addr", err_addr, 32'h5000_0000);

    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("clr_bus_err", bus_err, 0);
    chk("clr_err_addr", err_addr, 0);

    // 4a: response in the last allowed wait cycle is still accepted
    do_access(32'h2000_0040, 4'h0, 32'h0, 1'b0, TO, 32'hA5A5_0002, 1'b1, rb, wb, stb, saddr);
    chk("t4a_rbusy_cycles", rb, 15);
    chk("t4a_rdata", bus.mem_rdata, 32'hA5A5_0002);
    chk("t4a_bus_err", bus_err, 0);

    // 4b: slave 2 never answers
    do_access(32'h2000_0040, 4'h0, 32'h0, 1'b0, 0, 32'h0, 1'b0, rb, wb, stb, saddr);
    chk("t4b_strobe", stb, 8'h04);
    chk("t4b_rbusy_cycles", rb, 16);
    chk("t4b_rdata", bus.mem_rdata, 32'hDEAD_BEEF);
    chk("t4b_bus_err", bus_err, 1);
    chk("t4b_err_addr", err_addr, 32'h2000_0040);

    // good read from slave 3, then a write timeout must not touch read data or err_addr
    do_access(32'h3000_0000, 4'h0, 32'h0, 1'b0, 2, 32'h0BAD_F00D, 1'b0, rb, wb, stb, saddr);
    chk("t4c_rdata", bus.mem_rdata, 32'h0BAD_F00D);
    do_access(32'h2000_0080, 4'h3, 32'h1111_2222, 1'b0, 0, 32'h0, 1'b0, rb, wb, stb, saddr);
    chk("t4c_wbusy_cycles", wb, 16);
    chk("t4c_rdata_kept", bus.mem_rdata, 32'h0BAD_F00D);
    chk("t4c_err_addr_kept", err_addr, 32'h2000_0040);

    // 4d: err_clr coincident with a new error -> the new error is logged
    bus.mem_addr  = 32'h7000_0000;
    bus.mem_rstrb = 1'b1;
    step();
    bus.mem_rstrb = 1'b0;
    err_clr       = 1'b1;
    step();
    err_clr = 1'b0;
    chk("t4d_bus_err", bus_err, 1);
    chk("t4d_err_addr", err_addr, 32'h7000_0000);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("t4d_clr_bus_err", bus_err, 0);
    chk("t4d_clr_err_addr", err_addr, 0);

    // 5: asynchronous reset during RD_WAIT, then a late rvalid
    bus.mem_addr  = 32'h0000_0100;
    bus.mem_rstrb = 1'b1;
    step();
    bus.mem_rstrb = 1'b0;
    step();
    #2;
    reset_n = 1'b0;
    #1;
    chk("t5_rbusy_async", bus.mem_rbusy, 0);
    chk("t5_rdata_async", bus.mem_rdata, 0);
    chk("t5_state_async", dbg_state, 0);
    @(negedge clk);
    step();
    reset_n                 = 1'b1;
    bus.s_rvalid[0]         = 1'b1;
    bus.s_rdata[0*DW +: DW] = 32'h55AA_55AA;
    step();
    bus.s_rvalid = '0;
    @(negedge clk);
    chk("t5_late_rdata", bus.mem_rdata, 0);
    chk("t5_late_rbusy", bus.mem_rbusy, 0);
    step();

    // 6: read and write requested together -> only the write proceeds
    do_access(32'h1000_0008, 4'h1, 32'h0000_00AB, 1'b1, 2, 32'h0, 1'b0, rb, wb, stb, saddr);
    chk("t6_strobe", stb, 8'h20);
    chk("t6_wbusy_cycles", wb, 2);
    chk("t6_rbusy_cycles", rb, 0);

    repeat (3) step();
    chk("end_rd_q_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

endmodule
